// File: rtl/tsc_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tsc_multicycle_ctrl
//  Description : Multi-cycle FETCH/DECODE/EXEC/WB control FSM for the TSC CPU
//                datapath, with retired-instruction counter and halt/illegal
//                detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module tsc_multicycle_ctrl #(
    parameter int NUM_INST_WIDTH = 16,
    parameter int PC_LAST        = 27
) (
    input  logic                      clk,
    input  logic                      reset_cpu,
    input  logic                      cpu_enable,
    input  logic                      wwd_enable,
    output logic                      imem_req,
    input  logic                      imem_ready,
    input  logic [3:0]                opcode,
    input  logic [5:0]                func,
    input  logic [7:0]                pc,
    output logic                      ir_load,
    output logic                      pc_write,
    output logic                      pc_src,
    output logic                      reg_write,
    output logic                      reg_dst,
    output logic                      alu_src_imm,
    output logic                      alu_op,
    output logic                      wwd_valid,
    output logic                      halted,
    output logic                      done,
    output logic                      illegal,
    output logic [NUM_INST_WIDTH-1:0] num_inst,
    output logic [2:0]                state
);

    localparam logic [2:0] c_st_fetch  = 3'd0;
    localparam logic [2:0] c_st_decode = 3'd1;
    localparam logic [2:0] c_st_exec   = 3'd2;
    localparam logic [2:0] c_st_wb     = 3'd3;
    localparam logic [2:0] c_st_halt   = 3'd4;
    localparam logic [2:0] c_st_done   = 3'd5;

    localparam logic [2:0] c_cls_ill = 3'd0;
    localparam logic [2:0] c_cls_add = 3'd1;
    localparam logic [2:0] c_cls_adi = 3'd2;
    localparam logic [2:0] c_cls_lhi = 3'd3;
    localparam logic [2:0] c_cls_wwd = 3'd4;
    localparam logic [2:0] c_cls_hlt = 3'd5;
    localparam logic [2:0] c_cls_jmp = 3'd6;

    localparam logic [7:0] c_pc_last = 8'(PC_LAST);

    logic [2:0]                r_state;
    logic [2:0]                w_state_next;
    logic [2:0]                r_cls;
    logic [2:0]                w_cls_dec;
    logic [2:0]                w_cls;
    logic [NUM_INST_WIDTH-1:0] r_num_inst;
    logic                      w_retire;

    always_comb begin
        w_cls_dec = c_cls_ill;
        case (opcode)
            4'd15: begin
                case (func)
                    6'd0:    w_cls_dec = c_cls_add;
                    6'd28:   w_cls_dec = c_cls_wwd;
                    6'd29:   w_cls_dec = c_cls_hlt;
                    default: w_cls_dec = c_cls_ill;
                endcase
            end
            4'd4:    w_cls_dec = c_cls_adi;
            4'd6:    w_cls_dec = c_cls_lhi;
            4'd9:    w_cls_dec = c_cls_jmp;
            default: w_cls_dec = c_cls_ill;
        endcase
    end

    // The class is latched at the end of DECODE so EXEC/WB never depend on
    // the IR contents staying put.
    assign w_cls = (r_state == c_st_decode) ? w_cls_dec : r_cls;

    always_comb begin
        w_state_next = r_state;
        w_retire     = 1'b0;
        imem_req     = 1'b0;
        ir_load      = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 1'b0;
        reg_write    = 1'b0;
        reg_dst      = 1'b0;
        alu_src_imm  = 1'b0;
        alu_op       = 1'b0;
        wwd_valid    = 1'b0;
        halted       = 1'b0;
        done         = 1'b0;
        illegal      = 1'b0;
        if (!reset_cpu) begin
            if (r_state == c_st_decode || r_state == c_st_exec || r_state == c_st_wb) begin
                reg_dst     = (w_cls == c_cls_adi) || (w_cls == c_cls_lhi);
                alu_src_imm = (w_cls == c_cls_adi) || (w_cls == c_cls_lhi);
                alu_op      = (w_cls == c_cls_lhi);
                pc_src      = (w_cls == c_cls_jmp);
            end
            case (r_state)
                c_st_fetch: begin
                    imem_req = cpu_enable;
                    if (cpu_enable && imem_ready) begin
                        ir_load      = 1'b1;
                        w_state_next = c_st_decode;
                    end
                end
                c_st_decode: begin
                    illegal      = (w_cls == c_cls_ill);
                    w_state_next = c_st_exec;
                end
                c_st_exec: begin
                    if (w_cls == c_cls_jmp) begin
                        pc_write     = 1'b1;
                        w_retire     = 1'b1;
                        w_state_next = c_st_fetch;
                    end else begin
                        w_state_next = c_st_wb;
                    end
                end
                c_st_wb: begin
                    w_retire  = 1'b1;
                    reg_write = (w_cls == c_cls_add) || (w_cls == c_cls_adi) ||
                                (w_cls == c_cls_lhi);
                    wwd_valid = (w_cls == c_cls_wwd) && wwd_enable;
                    if (w_cls == c_cls_hlt) begin
                        w_state_next = c_st_halt;
                    end else if (pc == c_pc_last) begin
                        w_state_next = c_st_done;
                    end else begin
                        pc_write     = 1'b1;
                        w_state_next = c_st_fetch;
                    end
                end
                c_st_halt: halted = 1'b1;
                c_st_done: done   = 1'b1;
                default:   w_state_next = c_st_fetch;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset_cpu) begin
        if (reset_cpu) begin
            r_state <= c_st_fetch;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge reset_cpu) begin
        if (reset_cpu) begin
            r_cls      <= c_cls_ill;
            r_num_inst <= '0;
        end else begin
            if (r_state == c_st_decode) begin
                r_cls <= w_cls_dec;
            end
            if (w_retire) begin
                r_num_inst <= r_num_inst + NUM_INST_WIDTH'(1);
            end
        end
    end

    assign num_inst = r_num_inst;
    assign state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_tsc_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tsc_multicycle_ctrl
//  Description : Self-checking bench for tsc_multicycle_ctrl with an
//                instruction-level reference model and directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tsc_multicycle_ctrl;

    localparam int         c_w       = 16;
    localparam logic [7:0] c_pc_last = 8'd27;

    localparam int K_ILL = 0;
    localparam int K_ADD = 1;
    localparam int K_ADI = 2;
    localparam int K_LHI = 3;
    localparam int K_WWD = 4;
    localparam int K_HLT = 5;
    localparam int K_JMP = 6;

    logic           clk        = 1'b0;
    logic           reset_cpu  = 1'b1;
    logic           cpu_enable = 1'b0;
    logic           wwd_enable = 1'b0;
    logic           imem_ready = 1'b0;
    logic [3:0]     opcode     = 4'd0;
    logic [5:0]     func       = 6'd0;
    logic [7:0]     pc         = 8'd0;
    logic           imem_req, ir_load, pc_write, pc_src, reg_write, reg_dst;
    logic           alu_src_imm, alu_op, wwd_valid, halted, done, illegal;
    logic [c_w-1:0] num_inst;
    logic [2:0]     state;
    logic [11:0]    dut_vec;

    int checks   = 0;
    int failures = 0;

    tsc_multicycle_ctrl #(.NUM_INST_WIDTH(c_w), .PC_LAST(27)) dut (
        .clk(clk), .reset_cpu(reset_cpu), .cpu_enable(cpu_enable),
        .wwd_enable(wwd_enable), .imem_req(imem_req), .imem_ready(imem_ready),
        .opcode(opcode), .func(func), .pc(pc), .ir_load(ir_load),
        .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
        .reg_dst(reg_dst), .alu_src_imm(alu_src_imm), .alu_op(alu_op),
        .wwd_valid(wwd_valid), .halted(halted), .done(done), .illegal(illegal),
        .num_inst(num_inst), .state(state)
    );

    always #5 clk = ~clk;

    assign dut_vec = {imem_req, ir_load, pc_write, pc_src, reg_write, reg_dst,
                      alu_src_imm, alu_op, wwd_valid, halted, done, illegal};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int classify(input logic [3:0] op, input logic [5:0] fn);
        if (op == 4'd15 && fn == 6'd0)  return K_ADD;
        if (op == 4'd15 && fn == 6'd28) return K_WWD;
        if (op == 4'd15 && fn == 6'd29) return K_HLT;
        if (op == 4'd4)                 return K_ADI;
        if (op == 4'd6)                 return K_LHI;
        if (op == 4'd9)                 return K_JMP;
        return K_ILL;
    endfunction

    // Cycles after the fetch edge at which the instruction retires.
    function automatic int last_off(input int kind);
        return (kind == K_JMP) ? 2 : 3;
    endfunction

    // Reference model: mode 0 running, 1 halted, 2 done; off = cycles since fetch.
    int             m_mode  = 0;
    int             m_off   = 0;
    int             m_kind  = K_ILL;
    logic [c_w-1:0] m_count = '0;

    always @(posedge clk or posedge reset_cpu) begin
        if (reset_cpu) begin
            m_mode  <= 0;
            m_off   <= 0;
            m_kind  <= K_ILL;
            m_count <= '0;
        end else if (m_mode == 0) begin
            if (m_off == 0) begin
                if (cpu_enable && imem_ready) begin
                    m_off  <= 1;
                    m_kind <= classify(opcode, func);
                end
            end else if (m_off == last_off(m_kind)) begin
                m_count <= m_count + c_w'(1);
                m_off   <= 0;
                if (m_kind == K_HLT) m_mode <= 1;
                else if (m_kind != K_JMP && pc == c_pc_last) m_mode <= 2;
            end else begin
                m_off <= m_off + 1;
            end
        end
    end

    function automatic logic [11:0] model_outputs(input int mode, input int off, input int kind,
                                                  input logic rst, input logic cen, input logic rdy,
                                                  input logic wen, input logic [7:0] pcv);
        logic req, ld, pw, ps, rw, rd, ai, ao, wv, ht, dn, il;
        {req, ld, pw, ps, rw, rd, ai, ao, wv, ht, dn, il} = '0;
        if (!rst) begin
            if (mode == 1) ht = 1'b1;
            else if (mode == 2) dn = 1'b1;
            else if (off == 0) begin
                req = cen;
                ld  = cen & rdy;
            end else begin
                rd = (kind == K_ADI) || (kind == K_LHI);
                ai = rd;
                ao = (kind == K_LHI);
                ps = (kind == K_JMP);
                if (off == 1) il = (kind == K_ILL);
                if (off == last_off(kind)) begin
                    pw = (kind == K_JMP) || (kind != K_HLT && pcv != c_pc_last);
                    rw = (kind == K_ADD) || (kind == K_ADI) || (kind == K_LHI);
                    wv = (kind == K_WWD) && wen;
                end
            end
        end
        return {req, ld, pw, ps, rw, rd, ai, ao, wv, ht, dn, il};
    endfunction

    function automatic logic [2:0] model_state(input int mode, input int off);
        if (mode == 1) return 3'd4;
        if (mode == 2) return 3'd5;
        return 3'(off);
    endfunction

    always @(negedge clk) begin
        check("outputs", 32'(dut_vec),
              32'(model_outputs(m_mode, m_off, m_kind, reset_cpu, cpu_enable,
                                imem_ready, wwd_enable, pc)));
        check("state", 32'(state), 32'(model_state(m_mode, m_off)));
        check("num_inst", 32'(num_inst), 32'(m_count));
    end

    // Strobe counters used by the directed literal checks.
    int   n_ir = 0, n_pw = 0, n_rw = 0, n_wwd = 0, n_ill = 0;
    int   pw_state = 0;
    logic pw_src   = 1'b0;

    always @(negedge clk) begin
        if (!reset_cpu) begin
            if (ir_load)   n_ir  <= n_ir + 1;
            if (reg_write) n_rw  <= n_rw + 1;
            if (wwd_valid) n_wwd <= n_wwd + 1;
            if (illegal)   n_ill <= n_ill + 1;
            if (pc_write) begin
                n_pw     <= n_pw + 1;
                pw_state <= int'(state);
                pw_src   <= pc_src;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run_instr(input logic [3:0] op, input logic [5:0] fn,
                             input logic [7:0] pcv, input logic wen);
        opcode     = op;
        func       = fn;
        pc         = pcv;
        wwd_enable = wen;
        cpu_enable = 1'b1;
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        repeat ((op == 4'd9) ? 2 : 3) tick();
    endtask

    task automatic do_reset();
        reset_cpu = 1'b1;
        repeat (2) tick();
        reset_cpu = 1'b0;
    endtask

    int b_ir, b_pw, b_rw, b_wwd, b_ill;

    task automatic snap();
        b_ir  = n_ir;
        b_pw  = n_pw;
        b_rw  = n_rw;
        b_wwd = n_wwd;
        b_ill = n_ill;
    endtask

    initial begin
        // Reset with a fetch already offered: outputs must stay quiet.
        cpu_enable = 1'b1;
        imem_ready = 1'b1;
        opcode     = 4'd6;
        pc         = 8'd0;
        repeat (2) tick();
        @(negedge clk);
        check("rst_imem_req", 32'(imem_req), 0);
        check("rst_state", 32'(state), 0);
        check("rst_num_inst", 32'(num_inst), 0);
        tick();
        reset_cpu = 1'b0;

        // LHI walked cycle by cycle.
        @(negedge clk);
        check("lhi_c1_ir_load", 32'(ir_load), 1);
        tick();
        imem_ready = 1'b0;
        @(negedge clk);
        check("lhi_c2_state", 32'(state), 1);
        tick();
        tick();
        @(negedge clk);
        check("lhi_wb_strobes",
              32'({reg_write, reg_dst, alu_op, alu_src_imm, pc_write, pc_src}), 32'(6'b111110));
        tick();
        check("lhi_num_inst", 32'(num_inst), 1);

        // JMP at pc 16.
        snap();
        run_instr(4'd9, 6'd0, 8'd16, 1'b0);
        check("jmp_num_inst", 32'(num_inst), 2);
        check("jmp_pw_count", 32'(n_pw - b_pw), 1);
        check("jmp_pw_in_exec", 32'(pw_state), 2);
        check("jmp_pc_src", 32'(pw_src), 1);
        check("jmp_no_reg_write", 32'(n_rw - b_rw), 0);
        check("jmp_state", 32'(state), 0);

        // WWD enabled, then disabled.
        snap();
        run_instr(4'd15, 6'd28, 8'd17, 1'b1);
        check("wwd_en_pulse", 32'(n_wwd - b_wwd), 1);
        check("wwd_en_num", 32'(num_inst), 3);
        snap();
        run_instr(4'd15, 6'd28, 8'd18, 1'b0);
        check("wwd_dis_pulse", 32'(n_wwd - b_wwd), 0);
        check("wwd_dis_pw", 32'(n_pw - b_pw), 1);
        check("wwd_dis_num", 32'(num_inst), 4);

        // Illegal opcode behaves as a NOP, then HLT.
        snap();
        run_instr(4'd2, 6'd0, 8'd19, 1'b0);
        check("ill_pulse", 32'(n_ill - b_ill), 1);
        check("ill_no_reg_write", 32'(n_rw - b_rw), 0);
        check("ill_pc_src", 32'(pw_src), 0);
        check("ill_num", 32'(num_inst), 5);
        run_instr(4'd15, 6'd29, 8'd20, 1'b0);
        check("hlt_num", 32'(num_inst), 6);
        check("hlt_halted", 32'(halted), 1);
        snap();
        for (int i = 0; i < 4; i++) begin
            imem_ready = i[0];
            tick();
        end
        check("hlt_no_ir_load", 32'(n_ir - b_ir), 0);
        check("hlt_state", 32'(state), 4);

        // Asynchronous reset in the middle of ADI's EXEC.
        do_reset();
        snap();
        opcode     = 4'd4;
        pc         = 8'd3;
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        tick();
        #1;
        check("adi_in_exec", 32'(state), 2);
        reset_cpu = 1'b1;
        #1;
        check("async_rst_outputs", 32'(dut_vec), 0);
        check("async_rst_state", 32'(state), 0);
        repeat (2) tick();
        check("async_rst_no_write", 32'(n_rw - b_rw), 0);
        check("async_rst_num", 32'(num_inst), 0);
        reset_cpu = 1'b0;

        // FETCH wait with imem_ready low, then cpu_enable dropped.
        cpu_enable = 1'b1;
        imem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("wait_req", 32'({imem_req, state}), 32'(4'b1000));
        end
        cpu_enable = 1'b0;
        #1;
        check("dis_req", 32'(imem_req), 0);
        snap();
        imem_ready = 1'b1;
        repeat (2) tick();
        check("dis_no_ir_load", 32'(n_ir - b_ir), 0);

        // cpu_enable dropped after the fetch: instruction still completes.
        opcode     = 4'd15;
        func       = 6'd0;
        pc         = 8'd5;
        cpu_enable = 1'b1;
        tick();
        cpu_enable = 1'b0;
        imem_ready = 1'b0;
        repeat (5) tick();
        check("drop_num", 32'(num_inst), 1);
        check("drop_state", 32'(state), 0);

        // 28-instruction straight-line program ending with ADD at pc 27.
        do_reset();
        snap();
        for (int i = 0; i < 28; i++) begin
            case (i % 4)
                0:       run_instr(4'd15, 6'd0, 8'(i), 1'b1);
                1:       run_instr(4'd4, 6'd0, 8'(i), 1'b1);
                2:       run_instr(4'd6, 6'd0, 8'(i), 1'b1);
                default: begin
                    if (i == 27) run_instr(4'd15, 6'd0, 8'(i), 1'b1);
                    else         run_instr(4'd15, 6'd28, 8'(i), 1'b1);
                end
            endcase
        end
        check("run_num", 32'(num_inst), 28);
        check("run_done", 32'(done), 1);
        check("run_state", 32'(state), 5);
        check("run_pw_count", 32'(n_pw - b_pw), 27);
        check("run_rw_count", 32'(n_rw - b_rw), 22);
        snap();
        cpu_enable = 1'b1;
        imem_ready = 1'b1;
        repeat (3) tick();
        check("done_no_ir_load", 32'(n_ir - b_ir), 0);
        check("done_held", 32'(done), 1);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
